// File: rtl/mac_serial.sv
// mac_serial
// Serial signed multiply-accumulate. N_TERMS (operand, weight) pairs are
// accepted one per handshake, each product X*peso is summed into a 10-bit
// signed accumulator, and the completed dot product is presented on S with
// a valid/ready handshake.
//
// Parameters:
//   N_TERMS   pairs per result, legal range 1..7 (default 3)
// Ports:
//   clk       rising-edge clock
//   rst       synchronous, active-high reset
//   in_valid  X/peso pair offered this cycle
//   in_ready  block can accept a pair this cycle (NOT out_valid)
//   X         signed 4-bit operand
//   peso      signed 4-bit weight
//   S         signed 10-bit completed dot product (held until overwritten)
//   out_valid S holds a completed result
//   out_ready consumer takes S this cycle
//   term_cnt  pairs accepted so far in the current result
module mac_serial #(
    parameter int N_TERMS = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic signed [3:0] X,
    input  logic signed [3:0] peso,
    output logic signed [9:0] S,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        term_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Count value held while waiting for the final pair of a result.
    localparam logic [2:0] LAST_CNT = 3'(N_TERMS - 1);

    // Full signed product, sign-extended to accumulator width. Both operands
    // are widened first so the 10-bit multiply is exact (|product| <= 64).
    function automatic logic signed [9:0] mul_ext(
        input logic signed [3:0] a,
        input logic signed [3:0] b
    );
        logic signed [9:0] a_w;
        logic signed [9:0] b_w;
        a_w = {{6{a[3]}}, a};
        b_w = {{6{b[3]}}, b};
        return a_w * b_w;
    endfunction

    state_t            state_r;
    logic signed [9:0] acc_r;
    logic [2:0]        cnt_r;
    logic signed [9:0] s_r;
    logic              out_valid_r;

    logic              accept_s;
    logic signed [9:0] prod_s;
    logic signed [9:0] sum_s;

    // Handshake and datapath terms for the current cycle.
    always_comb begin
        accept_s = in_valid & ~out_valid_r;
        prod_s   = mul_ext(X, peso);
        sum_s    = acc_r + prod_s;
    end

    // Control state machine with accumulator, result and count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            acc_r       <= 10'sd0;
            cnt_r       <= 3'd0;
            s_r         <= 10'sd0;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        if (N_TERMS == 1) begin
                            // Single-term result completes on the first pair.
                            s_r         <= prod_s;
                            out_valid_r <= 1'b1;
                            acc_r       <= 10'sd0;
                            cnt_r       <= 3'd0;
                            state_r     <= DONE;
                        end else begin
                            acc_r   <= prod_s;
                            cnt_r   <= 3'd1;
                            state_r <= ACC;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACC: begin
                    if (accept_s) begin
                        if (cnt_r == LAST_CNT) begin
                            // Final pair: publish the sum and clear for the
                            // next result so IDLE always starts from zero.
                            s_r         <= sum_s;
                            out_valid_r <= 1'b1;
                            acc_r       <= 10'sd0;
                            cnt_r       <= 3'd0;
                            state_r     <= DONE;
                        end else begin
                            acc_r <= sum_s;
                            cnt_r <= cnt_r + 3'd1;
                        end
                    end else begin
                        state_r <= ACC;
                    end
                end
                DONE: begin
                    // in_ready is low here, so no pair can be taken in the
                    // same cycle the result is consumed.
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    acc_r       <= 10'sd0;
                    cnt_r       <= 3'd0;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = ~out_valid_r;
    assign S         = s_r;
    assign out_valid = out_valid_r;
    assign term_cnt  = cnt_r;

endmodule

// File: doc/mac_serial.md
MAC_SERIAL -- requirements
Module: mac_serial

Interface
REQ-001 The block SHALL have parameter N_TERMS, default 3, giving the number of (operand, weight) pairs per result; legal range 1..7.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the X/peso pair is valid this cycle.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block accepts a pair this cycle.
REQ-006 The block SHALL have port X, input, 4 bits signed: operand.
REQ-007 The block SHALL have port peso, input, 4 bits signed: weight for X.
REQ-008 The block SHALL have port S, output, 10 bits signed: accumulated dot product.
REQ-009 The block SHALL have port out_valid, output, 1 bit: S holds a completed result.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer takes S this cycle.
REQ-011 The block SHALL have port term_cnt, output, 3 bits: the number of pairs accepted in the current result, 0..N_TERMS-1.

Function
REQ-012 A pair SHALL be accepted only on a cycle with in_valid=1 and in_ready=1; X and peso are sampled at that edge.
REQ-013 in_ready SHALL be combinational and equal to NOT out_valid.
REQ-014 Each product SHALL be a full signed 8-bit product X*peso, sign-extended to 10 bits before it is added.
REQ-015 The accumulation SHALL be 10-bit signed, with no saturation and no overflow possible (|sum| <= 7*64 = 448).
REQ-016 The block SHALL implement states IDLE (term_cnt=0, accumulator cleared), ACC (0<term_cnt<N_TERMS), and DONE (out_valid=1).
REQ-017 In IDLE, an accepted pair SHALL load acc=X*peso; the next state is ACC, or DONE when N_TERMS=1.
REQ-018 In ACC, an accepted pair SHALL add X*peso to acc and increment term_cnt.
REQ-019 When the accepted pair is pair number N_TERMS, the block SHALL write S=acc+X*peso, set out_valid=1 at that edge, and return term_cnt to 0.
REQ-020 With N_TERMS pairs presented back-to-back, the latency SHALL be exactly 1 cycle from acceptance of the last pair to out_valid=1.
REQ-021 Cycles with in_valid=0 SHALL leave acc and term_cnt unchanged; gaps between pairs are allowed.
REQ-022 In DONE, S and out_valid SHALL hold stable until a cycle with out_ready=1; at that edge out_valid goes to 0 and the state goes to IDLE.
REQ-023 No pair SHALL be accepted in the cycle in which out_valid=1 and out_ready=1; the next result can start one cycle later.
REQ-024 S SHALL keep the last result after it is consumed, until it is overwritten by the next completion.
REQ-025 out_ready SHALL be ignored while out_valid=0.

Reset
REQ-026 When rst=1 at a clock edge, the block SHALL set S=0, out_valid=0, term_cnt=0, acc=0, and state=IDLE, from any state.
REQ-027 A partial accumulation SHALL be discarded by reset mid-operation; after reset the next accepted pair starts a new result.
REQ-028 rst SHALL take priority over in_valid and out_ready in the same cycle.
REQ-029 in_ready SHALL be 1 in the first cycle after reset.

Verification
REQ-030 The bench SHALL cover this scenario with N_TERMS=3 and out_ready=1: pairs (2,2), (-3,3), (1,-4) back-to-back -> S=-9, with out_valid=1 exactly one cycle after the third pair is accepted.
REQ-031 The bench SHALL cover this scenario: pairs (-8,1), (7,-2), (-2,3) with idle cycles between pairs -> S=-28, and term_cnt goes 0,1,2,0.
REQ-032 The bench SHALL cover this scenario: pairs (5,-1) x3 with out_ready=0 for 5 cycles -> S=-15 held stable, in_ready=0 throughout, and a pair offered in that window is not accepted.
REQ-033 The bench SHALL cover these extremes: pairs (-8,-8) x3 -> S=192; pairs (-8,7) x3 -> S=-168; no wrap-around.
REQ-034 The bench SHALL cover this scenario: accept (4,4), (4,4), then assert rst for 1 cycle, then send (4,4) x3 -> S=48 (not 80), and out_valid=0 and S=0 immediately after reset.
REQ-035 The bench SHALL cover this scenario: out_valid and out_ready both high while in_valid=1 -> the pair is not accepted that cycle and is accepted in the next cycle as pair 1.
